multicycle_control_unit: RTL and testbench

- Sequencing FSM for the multicycle version of the MIPS datapath, which shares one memory, one ALU and one register file across instruction steps.
- Takes the instruction opcode, the ALU zero flag and a memory ready handshake.
- Drives every datapath select and write enable cycle by cycle.
- Also reports retired-instruction count, illegal-opcode and memory-timeout events.

---
 rtl/multicycle_control_unit_if.sv | 39 +++
 rtl/multicycle_control_unit.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit_if
// Brief    : Datapath-facing bus of the multicycle MIPS control unit.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : Sequencing FSM for the shared-resource multicycle MIPS datapath.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    multicycle_control_unit_if.master  bus,
    output logic [3:0]                 state,
    output logic                       illegal_op,
    output logic                       bus_error,
    output logic [CNT_W-1:0]           instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;

    localparam int              WAIT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] c_timeout = WAIT_W'(TIMEOUT);

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]    r_count;

    logic       w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write;
    logic       w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
    logic [1:0] w_alu_src_b, w_pc_source;
    logic [2:0] w_alu_op;
    logic       w_mem_state, w_retire, w_illegal, w_timeout;

    // The zero qualification of pc_write_cond happens in the datapath.
    logic w_unused_zero;
    assign w_unused_zero = bus.zero;

    always_comb begin
        w_next          = r_state;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 3'b000;
        w_pc_source     = 2'b00;
        w_mem_state     = 1'b0;
        w_retire        = 1'b0;
        w_illegal       = 1'b0;
        w_timeout       = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
                w_mem_state = 1'b1;
                if (bus.mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (bus.opcode)
                    c_op_lw, c_op_sw: w_next = S_MEMADR;
                    c_op_rtype:       w_next = S_EXEC;
                    c_op_beq:         w_next = S_BRANCH;
                    c_op_addi:        w_next = S_ADDIEX;
                    c_op_j:           w_next = S_JUMP;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = (bus.opcode == c_op_sw) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_mem_read  = 1'b1;
                w_i_or_d    = 1'b1;
                w_mem_state = 1'b1;
                if (bus.mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                w_mem_state = 1'b1;
                if (bus.mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 3'b010;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 3'b001;
                w_pc_source     = 2'b01;
                w_pc_write_cond = 1'b1;
                w_retire        = 1'b1;
                w_next          = S_FETCH;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                w_pc_source = 2'b10;
                w_pc_write  = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase

        // A ready arriving in the limit cycle wins over the timeout.
        if ((TIMEOUT > 0) && w_mem_state && !bus.mem_ready && (r_wait_cnt == c_timeout)) begin
            w_timeout = 1'b1;
            w_next    = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_next;
            if (w_timeout || (w_next != r_state))
                r_wait_cnt <= '0;
            else if (w_mem_state && !bus.mem_ready)
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            if (w_retire)
                r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.pc_write      = w_pc_write & ~reset;
    assign bus.pc_write_cond = w_pc_write_cond & ~reset;
    assign bus.ir_write      = w_ir_write & ~reset;
    assign bus.reg_write     = w_reg_write & ~reset;
    assign bus.mem_write     = w_mem_write & ~reset;
    assign bus.i_or_d        = w_i_or_d;
    assign bus.mem_read      = w_mem_read;
    assign bus.mem_to_reg    = w_mem_to_reg;
    assign bus.reg_dst       = w_reg_dst;
    assign bus.alu_src_a     = w_alu_src_a;
    assign bus.alu_src_b     = w_alu_src_b;
    assign bus.alu_op        = w_alu_op;
    assign bus.pc_source     = w_pc_source;

    assign state       = r_state;
    assign illegal_op  = w_illegal & ~reset;
    assign bus_error   = w_timeout & ~reset;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Brief    : Directed scoreboard bench for the multicycle MIPS control unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    typedef struct packed {
        logic [3:0]  st;
        ctrl_t       ctrl;
        logic        ill;
        logic        berr;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  state, state_s;
    logic        illegal_op, illegal_op_s;
    logic        bus_error, bus_error_s;
    logic [31:0] instr_count;
    logic [2:0]  instr_count_s;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_step   = 0;
    logic [31:0] exp_cnt = '0;
    exp_t sb[$];

    multicycle_control_unit_if u_if ();
    multicycle_control_unit_if u_if_s ();

    assign u_if_s.opcode    = u_if.opcode;
    assign u_if_s.zero      = u_if.zero;
    assign u_if_s.mem_ready = u_if.mem_ready;

    multicycle_control_unit #(.CNT_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .bus(u_if),
        .state(state), .illegal_op(illegal_op), .bus_error(bus_error),
        .instr_count(instr_count)
    );

    // Narrow counter instance shares all stimulus to exercise wrap-around.
    multicycle_control_unit #(.CNT_W(3), .TIMEOUT(4)) dut_s (
        .clk(clk), .reset(reset), .bus(u_if_s),
        .state(state_s), .illegal_op(illegal_op_s), .bus_error(bus_error_s),
        .instr_count(instr_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic mr, input logic rst);
        ctrl_t c;
        c = '0;
        case (st)
            4'd0:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            4'd1:  c.alu_src_b = 2'b11;
            4'd2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            4'd3:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            4'd4:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            4'd5:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            4'd6:  begin c.alu_src_a = 1'b1; c.alu_op = 3'b010; end
            4'd7:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            4'd8:  begin c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_source = 2'b01; c.pc_write_cond = 1'b1; end
            4'd9:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            4'd10: c.reg_write = 1'b1;
            4'd11: begin c.pc_source = 2'b10; c.pc_write = 1'b1; end
            default: c = '0;
        endcase
        if (rst) begin
            c.pc_write = 1'b0; c.pc_write_cond = 1'b0; c.ir_write = 1'b0;
            c.reg_write = 1'b0; c.mem_write = 1'b0;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, n_step, obs, expv);
        end
    endtask

    // One clock cycle: queue the expectation, compare mid-cycle, advance.
    task automatic step(input logic [3:0] st, input logic ill, input logic berr, input logic retire);
        exp_t  e;
        ctrl_t o;
        e.st   = st;
        e.ctrl = exp_ctrl(st, u_if.mem_ready, reset);
        e.ill  = ill;
        e.berr = berr;
        e.cnt  = exp_cnt;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        o = {u_if.pc_write, u_if.pc_write_cond, u_if.i_or_d, u_if.mem_read, u_if.mem_write,
             u_if.ir_write, u_if.mem_to_reg, u_if.reg_dst, u_if.reg_write, u_if.alu_src_a,
             u_if.alu_src_b, u_if.alu_op, u_if.pc_source};
        check("state", 64'(state), 64'(e.st));
        check("ctrl", 64'(o), 64'(e.ctrl));
        check("flags", 64'({illegal_op, bus_error}), 64'({e.ill, e.berr}));
        check("instr_count", 64'(instr_count), 64'(e.cnt));
        check("instr_count_narrow", 64'(instr_count_s), 64'(e.cnt[2:0]));
        n_step++;
        @(posedge clk);
        #1;
        if (reset)       exp_cnt = '0;
        else if (retire) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic fetch(input logic [5:0] op);
        u_if.opcode    = op;
        u_if.mem_ready = 1'b1;
        step(4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        u_if.opcode    = 6'b000000;
        u_if.zero      = 1'b0;
        u_if.mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held: FETCH with write enables suppressed.
        step(4'd0, 1'b0, 1'b0, 1'b0);
        step(4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // R-type
        fetch(6'b000000);
        step(4'd1, 1'b0, 1'b0, 1'b0);
        step(4'd6, 1'b0, 1'b0, 1'b0);
        step(4'd7, 1'b0, 1'b0, 1'b1);

        // lw with three wait cycles
        fetch(6'b100011);
        step(4'd1, 1'b0, 1'b0, 1'b0);
        step(4'd2, 1'b0, 1'b0, 1'b0);
        u_if.mem_ready = 1'b0;
        repeat (3) step(4'd3, 1'b0, 1'b0, 1'b0);
        u_if.mem_ready = 1'b1;
        step(4'd3, 1'b0, 1'b0, 1'b0);
        step(4'd4, 1'b0, 1'b0, 1'b1);

        // beq taken, then j
        u_if.zero = 1'b1;
        fetch(6'b000100);
        step(4'd1, 1'b0, 1'b0, 1'b0);
        step(4'd8, 1'b0, 1'b0, 1'b1);
        u_if.zero = 1'b0;
        fetch(6'b000010);
        step(4'd1, 1'b0, 1'b0, 1'b0);
        step(4'd11, 1'b0, 1'b0, 1'b1);

        // addi
        fetch(6'b001000);
        step(4'd1, 1'b0, 1'b0, 1'b0);
        step(4'd9, 1'b0, 1'b0, 1'b0);
        step(4'd10, 1'b0, 1'b0, 1'b1);

        // sw, no wait
        fetch(6'b101011);
        step(4'd1, 1'b0, 1'b0, 1'b0);
        step(4'd2, 1'b0, 1'b0, 1'b0);
        step(4'd5, 1'b0, 1'b0, 1'b1);

        // FETCH stalled one cycle
        u_if.opcode    = 6'b000000;
        u_if.mem_ready = 1'b0;
        step(4'd0, 1'b0, 1'b0, 1'b0);
        fetch(6'b000000);
        step(4'd1, 1'b0, 1'b0, 1'b0);
        step(4'd6, 1'b0, 1'b0, 1'b0);
        step(4'd7, 1'b0, 1'b0, 1'b1);

        // Illegal opcode
        fetch(6'b111111);
        step(4'd1, 1'b1, 1'b0, 1'b0);

        // sw timing out; mem_ready outside memory states ignored
        fetch(6'b101011);
        u_if.mem_ready = 1'b0;
        step(4'd1, 1'b0, 1'b0, 1'b0);
        step(4'd2, 1'b0, 1'b0, 1'b0);
        repeat (4) step(4'd5, 1'b0, 1'b0, 1'b0);
        step(4'd5, 1'b0, 1'b1, 1'b0);

        // sw completing exactly at the limit
        fetch(6'b101011);
        step(4'd1, 1'b0, 1'b0, 1'b0);
        step(4'd2, 1'b0, 1'b0, 1'b0);
        u_if.mem_ready = 1'b0;
        repeat (4) step(4'd5, 1'b0, 1'b0, 1'b0);
        u_if.mem_ready = 1'b1;
        step(4'd5, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a MEMRD wait
        fetch(6'b100011);
        step(4'd1, 1'b0, 1'b0, 1'b0);
        step(4'd2, 1'b0, 1'b0, 1'b0);
        u_if.mem_ready = 1'b0;
        repeat (2) step(4'd3, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step(4'd3, 1'b0, 1'b0, 1'b0);
        u_if.mem_ready = 1'b1;
        step(4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Eight jumps: narrow counter wraps 7 -> 0
        for (int k = 0; k < 8; k++) begin
            fetch(6'b000010);
            step(4'd1, 1'b0, 1'b0, 1'b0);
            step(4'd11, 1'b0, 1'b0, 1'b1);
        end
        fetch(6'b000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
